// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock FIFO slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEF_DEPTH, DEF_DAT_BITS : default geometry shared by interface and modules
//   cnt_bits()              : width of a 0..depth occupancy counter
package sync_fifo_pkg;

    localparam int DEF_DEPTH    = 5;
    localparam int DEF_DAT_BITS = 8;

    // Occupancy runs 0..depth inclusive, so it needs one more code than a pointer.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Valid/ready stream plus status bundle for sync_fifo.
// Latency: n/a (wires only).
// Backpressure: o_rdy back to the writer, i_rdy from the reader.
//
// slave  : the FIFO side (takes writes/read-ready/flush, drives data and status)
// master : the user side (drives writes/read-ready/flush, observes data and status)
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DAT_BITS = DEF_DAT_BITS
);
    localparam int CBITS = cnt_bits(DEPTH);

    // write side
    logic                i_val;
    logic [DAT_BITS-1:0] i_dat;
    logic                o_rdy;

    // read side
    logic                o_val;
    logic [DAT_BITS-1:0] o_dat;
    logic                i_rdy;

    // control and status
    logic                i_flush;
    logic                o_full;
    logic                o_emp;
    logic                o_afull;
    logic                o_aemp;
    logic [CBITS-1:0]    o_wrds;
    logic                o_ovf;

    modport slave (
        input  i_val, i_dat, i_rdy, i_flush,
        output o_rdy, o_val, o_dat,
        output o_full, o_emp, o_afull, o_aemp, o_wrds, o_ovf
    );

    modport master (
        output i_val, i_dat, i_rdy, i_flush,
        input  o_rdy, o_val, o_dat,
        input  o_full, o_emp, o_afull, o_aemp, o_wrds, o_ovf
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DAT_BITS register array backing sync_fifo.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the caller only writes free slots and reads occupied ones.
//
// Ports:
//   i_clk         write clock
//   i_we, i_waddr, i_wdat   synchronous write port
//   i_raddr, o_rdat         asynchronous read port
// Contents are deliberately not reset: every slot is written before it is read.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DAT_BITS = DEF_DAT_BITS,
    parameter int ABITS    = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [ABITS-1:0]    i_waddr,
    input  logic [DAT_BITS-1:0] i_wdat,
    input  logic [ABITS-1:0]    i_raddr,
    output logic [DAT_BITS-1:0] o_rdat
);

    logic [DAT_BITS-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO, any depth >= 2, with registered head-of-queue output stage.
// Latency: a write into an empty FIFO is visible on o_val/o_dat one cycle later.
// Backpressure: o_rdy = ~full (never depends on i_rdy); writes while full are dropped and set sticky o_ovf.
//
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   fif (slave)    : i_val/i_dat/o_rdy write stream, o_val/o_dat/i_rdy read stream,
//                    i_flush, and status o_full/o_emp/o_afull/o_aemp/o_wrds/o_ovf
// All status flags decode the registered count, so none has a path from i_val/i_rdy/i_flush.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DAT_BITS  = DEF_DAT_BITS,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int AEMP_LVL  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    sync_fifo_if.slave fif
);

    localparam int CBITS = cnt_bits(DEPTH);
    localparam int PBITS = $clog2(DEPTH);

    typedef logic [PBITS-1:0] ptr_t;
    typedef logic [CBITS-1:0] cnt_t;

    // Pointers walk 0..DEPTH-1 and wrap explicitly, so non-power-of-2 depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // registered state
    ptr_t                wr_ptr;
    ptr_t                rd_ptr;
    cnt_t                count;
    logic                val_q;
    logic [DAT_BITS-1:0] dat_q;
    logic                ovf_q;

    // next-state
    ptr_t                wr_ptr_n;
    ptr_t                rd_ptr_n;
    cnt_t                count_n;
    logic                val_n;
    logic [DAT_BITS-1:0] dat_n;
    logic                ovf_n;

    // datapath helpers
    logic                full;
    logic                push;
    logic                pop;
    logic                mem_we;
    ptr_t                head_ptr;
    logic                head_is_new;
    logic [DAT_BITS-1:0] mem_rdat;

    assign full = (count == cnt_t'(DEPTH));
    assign push = fif.i_val & ~full;
    assign pop  = val_q & fif.i_rdy;

    // The word in the output register still occupies mem[rd_ptr]; a pop frees it
    // and exposes the next slot as the new head.
    assign head_ptr = pop ? ptr_inc(rd_ptr) : rd_ptr;

    // After this cycle's pop, no stored word remains unread: the head slot is
    // the one being written right now, so it must come from i_dat, not memory.
    assign head_is_new = pop ? (count == cnt_t'(1)) : (count == '0);

    // A write in the flush cycle is discarded, so keep it out of storage too.
    assign mem_we = push & ~fif.i_flush;

    sync_fifo_mem #(
        .DEPTH    (DEPTH),
        .DAT_BITS (DAT_BITS),
        .ABITS    (PBITS)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wr_ptr),
        .i_wdat  (fif.i_dat),
        .i_raddr (head_ptr),
        .o_rdat  (mem_rdat)
    );

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        val_n    = val_q;
        dat_n    = dat_q;
        ovf_n    = ovf_q;

        if (fif.i_flush) begin
            // o_dat intentionally holds its last value across a flush.
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
            val_n    = 1'b0;
            ovf_n    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_n = ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr_n = head_ptr;
            end

            unique case ({push, pop})
                2'b10:   count_n = count + cnt_t'(1);
                2'b01:   count_n = count - cnt_t'(1);
                default: count_n = count;
            endcase

            if (fif.i_val & full) begin
                ovf_n = 1'b1;
            end

            val_n = (count_n != '0);

            // Reload the output register whenever it is empty or being consumed.
            // With nothing left to show, hold o_dat rather than load stale memory.
            if (~val_q | pop) begin
                if (head_is_new) begin
                    if (push) begin
                        dat_n = fif.i_dat;
                    end
                end else begin
                    dat_n = mem_rdat;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            val_q  <= 1'b0;
            dat_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            val_q  <= val_n;
            dat_q  <= dat_n;
            ovf_q  <= ovf_n;
        end
    end

    assign fif.o_rdy   = ~full;
    assign fif.o_val   = val_q;
    assign fif.o_dat   = dat_q;
    assign fif.o_full  = full;
    assign fif.o_emp   = (count == '0);
    assign fif.o_afull = (count >= cnt_t'(AFULL_LVL));
    assign fif.o_aemp  = (count <= cnt_t'(AEMP_LVL));
    assign fif.o_wrds  = count;
    assign fif.o_ovf   = ovf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed checks of sync_fifo against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_fifo;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int AFL   = 4;
    localparam int AEL   = 1;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    sync_fifo_if #(.DEPTH(DEPTH), .DAT_BITS(DW)) fif ();

    sync_fifo #(
        .DEPTH     (DEPTH),
        .DAT_BITS  (DW),
        .AFULL_LVL (AFL),
        .AEMP_LVL  (AEL)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .fif     (fif.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: contents in arrival order plus the sticky overflow bit
    logic [DW-1:0] m_q [$];
    logic          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, "_val"},   32'(fif.o_val),   32'(sz != 0));
        if (sz != 0) begin
            chk({tag, "_dat"}, 32'(fif.o_dat), 32'(m_q[0]));
        end
        chk({tag, "_wrds"},  32'(fif.o_wrds),  32'(sz));
        chk({tag, "_full"},  32'(fif.o_full),  32'(sz == DEPTH));
        chk({tag, "_emp"},   32'(fif.o_emp),   32'(sz == 0));
        chk({tag, "_afull"}, 32'(fif.o_afull), 32'(sz >= AFL));
        chk({tag, "_aemp"},  32'(fif.o_aemp),  32'(sz <= AEL));
        chk({tag, "_rdy"},   32'(fif.o_rdy),   32'(sz != DEPTH));
        chk({tag, "_ovf"},   32'(fif.o_ovf),   32'(m_ovf));
    endtask

    // Drive one cycle of stimulus, advance the model by the same rules, then
    // check every output just after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        logic full_m;
        fif.i_val   = v;
        fif.i_dat   = d;
        fif.i_rdy   = r;
        fif.i_flush = f;
        full_m = (m_q.size() == DEPTH);
        if (f) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (v && full_m) m_ovf = 1'b1;
            if (r && m_q.size() != 0) void'(m_q.pop_front());
            if (v && !full_m) m_q.push_back(d);
        end
        @(posedge i_clk);
        #1;
        check_all("cyc");
    endtask

    initial begin
        int pv;
        int pr;
        fif.i_val   = 1'b0;
        fif.i_dat   = '0;
        fif.i_rdy   = 1'b0;
        fif.i_flush = 1'b0;
        m_ovf       = 1'b0;

        // reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_all("rst");
        chk("rst_dat", 32'(fif.o_dat), 32'h0);
        i_rst_n = 1'b1;

        // single push, reader stalled
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        chk("s1_dat",  32'(fif.o_dat),  32'h11);
        chk("s1_wrds", 32'(fif.o_wrds), 32'd1);
        chk("s1_aemp", 32'(fif.o_aemp), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // fill to full, then overflow
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 3) chk("s2_afull_lo", 32'(fif.o_afull), 32'd0);
            if (i == 4) chk("s2_afull_hi", 32'(fif.o_afull), 32'd1);
        end
        chk("s2_full", 32'(fif.o_full), 32'd1);
        chk("s2_rdy",  32'(fif.o_rdy),  32'd0);
        chk("s2_wrds", 32'(fif.o_wrds), 32'd5);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        chk("s2_ovf",   32'(fif.o_ovf),  32'd1);
        chk("s2_wrds6", 32'(fif.o_wrds), 32'd5);

        // drain in order, one word per cycle
        for (int i = 1; i <= 5; i++) begin
            chk("s3_dat", 32'(fif.o_dat), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("s3_emp", 32'(fif.o_emp), 32'd1);

        // streaming with constant occupancy across several pointer wraps
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        cycle(1'b1, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h82 + i), 1'b1, 1'b0);
            chk("s4_wrds", 32'(fif.o_wrds), 32'd2);
            chk("s4_seq",  32'(fif.o_dat),  32'(8'(8'h81 + i)));
        end

        // flush with simultaneous push and pop
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("s5_wrds", 32'(fif.o_wrds), 32'd0);
        chk("s5_val",  32'(fif.o_val),  32'd0);
        chk("s5_ovf",  32'(fif.o_ovf),  32'd0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        chk("s5_dat", 32'(fif.o_dat), 32'h77);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s5_emp", 32'(fif.o_emp), 32'd1);

        // asynchronous reset between clock edges
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("s6_val",  32'(fif.o_val),  32'd0);
        chk("s6_wrds", 32'(fif.o_wrds), 32'd0);
        chk("s6_dat",  32'(fif.o_dat),  32'h0);
        m_q.delete();
        m_ovf = 1'b0;
        fif.i_val = 1'b0;
        fif.i_rdy = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        check_all("s6");

        // random traffic with varying write/read pressure
        for (int seg = 0; seg < 8; seg++) begin
            pv = int'($urandom_range(1, 9));
            pr = int'($urandom_range(1, 9));
            for (int c = 0; c < 50; c++) begin
                cycle(int'($urandom_range(0, 9)) < pv,
                      8'($urandom),
                      int'($urandom_range(0, 9)) < pr,
                      $urandom_range(0, 59) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
